// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: response codes, burst limits, R-beat record,
// scheduler state encoding and a small modulo-increment helper.
package axi_node_pkg;

    localparam int AXI4_MAX_BURST = 256;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int R_BEAT_DATA_W = 64;
    localparam int R_BEAT_USER_W = 6;

    typedef struct packed {
        logic [R_BEAT_DATA_W-1:0] data;
        logic [1:0]               resp;
        logic                     last;
        logic [R_BEAT_USER_W-1:0] user;
    } r_beat_t;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } sched_state_t;

    // Increment an index modulo n with an explicit compare so that
    // non-power-of-two port counts wrap correctly.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_r_burst_scheduler_if.sv
// Bundle of the N upstream R channels and the single shared downstream R channel.
interface axi_r_burst_scheduler_if #(
    parameter int N_INIT_PORT = 4,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int AXI_ID_IN   = 16,
    parameter int AXI_ID_OUT  = AXI_ID_IN + 2
);

    logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0] rid_i;
    logic [N_INIT_PORT-1:0][AXI_DATA_W-1:0] rdata_i;
    logic [N_INIT_PORT-1:0][1:0]            rresp_i;
    logic [N_INIT_PORT-1:0]                 rlast_i;
    logic [N_INIT_PORT-1:0][AXI_USER_W-1:0] ruser_i;
    logic [N_INIT_PORT-1:0]                 rvalid_i;
    logic [N_INIT_PORT-1:0]                 rready_o;

    logic [AXI_ID_IN-1:0]  rid_o;
    logic [AXI_DATA_W-1:0] rdata_o;
    logic [1:0]            rresp_o;
    logic                  rlast_o;
    logic [AXI_USER_W-1:0] ruser_o;
    logic                  rvalid_o;
    logic                  rready_i;

    // Scheduler side: consumes the upstream beats, drives the shared channel.
    modport slave (
        input  rid_i, rdata_i, rresp_i, rlast_i, ruser_i, rvalid_i, rready_i,
        output rready_o, rid_o, rdata_o, rresp_o, rlast_o, ruser_o, rvalid_o
    );

    // Environment side: sources the upstream beats and the downstream ready.
    modport master (
        output rid_i, rdata_i, rresp_i, rlast_i, ruser_i, rvalid_i, rready_i,
        input  rready_o, rid_o, rdata_o, rresp_o, rlast_o, ruser_o, rvalid_o
    );

endinterface

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer.
module axi_rr_pick #(
    parameter int N = 4,
    localparam int LOG_N = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [LOG_N-1:0] ptr_i,
    output logic [LOG_N-1:0] idx_o,
    output logic             any_o
);

    int cand;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        idx_o = ptr_i;
        any_o = |req_i;
        cand  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req_i[cand]) begin
                idx_o = LOG_N'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_r_burst_scheduler.sv
// Round-robin R-channel scheduler that locks the grant for a whole burst,
// strips the routing bits from RID and flags over-length bursts.
module axi_r_burst_scheduler
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT = 4,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int AXI_ID_IN   = 16,
    parameter int AXI_ID_OUT  = AXI_ID_IN + 2,
    parameter int LOG_N_INIT  = $clog2(N_INIT_PORT),
    parameter int MAX_BEATS   = AXI4_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_r_burst_scheduler_if.slave bus,
    output logic [LOG_N_INIT-1:0] grant_o,
    output logic                  busy_o,
    output logic                  protocol_err_o,
    input  logic                  clr_err_i
);

    sched_state_t          state_q, state_d;
    logic [LOG_N_INIT-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOG_N_INIT-1:0] lock_idx_q, lock_idx_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;

    logic [LOG_N_INIT-1:0]  pick_idx;
    logic                   pick_any;
    logic [LOG_N_INIT-1:0]  sel;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   hs;
    logic                   violation;
    logic [N_INIT_PORT-1:0] ready_vec;

    axi_rr_pick #(.N(N_INIT_PORT)) u_pick (
        .req_i (bus.rvalid_i),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Zero-latency beat mux; everything is masked while reset is held.
    always_comb begin
        sel       = (state_q == ST_LOCKED) ? lock_idx_q : pick_idx;
        sel_valid = (state_q == ST_LOCKED) ? bus.rvalid_i[lock_idx_q] : pick_any;
        sel_last  = bus.rlast_i[sel];
        hs        = sel_valid & bus.rready_i & ~rst;
        ready_vec = '0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            ready_vec[i] = bus.rready_i & ~rst & (sel == LOG_N_INIT'(i));
        end
        bus.rready_o   = ready_vec;
        bus.rvalid_o   = sel_valid & ~rst;
        bus.rid_o      = bus.rid_i[sel][AXI_ID_IN-1:0];
        bus.rdata_o    = bus.rdata_i[sel];
        bus.rresp_o    = bus.rresp_i[sel];
        bus.rlast_o    = sel_last;
        bus.ruser_o    = bus.ruser_i[sel];
        grant_o        = rst ? '0 : sel;
        busy_o         = (state_q == ST_LOCKED);
        protocol_err_o = err_q;
    end

    // Next-state: burst lock/unlock, pointer advance, beat count and sticky error.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        beat_cnt_d = beat_cnt_q;
        violation  = hs & ~sel_last &
                     (({1'b0, beat_cnt_q} + 10'd1) == 10'(MAX_BEATS));
        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    if (sel_last) begin
                        rr_ptr_d = LOG_N_INIT'(wrap_inc(int'(sel), N_INIT_PORT));
                    end else begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = sel;
                        beat_cnt_d = 9'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (hs) begin
                    if (sel_last) begin
                        state_d    = ST_IDLE;
                        rr_ptr_d   = LOG_N_INIT'(wrap_inc(int'(lock_idx_q), N_INIT_PORT));
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q != 9'h1FF) begin
                        beat_cnt_d = beat_cnt_q + 9'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (violation) begin
            err_d = 1'b1;
        end else if (clr_err_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule
